// File: rtl/result_collector_pkg.sv
// rtl/result_collector_pkg.sv - shared types, defaults and sizing helper for result_collector
// Contents:
//   state_t     : collector FSM states (COLLECT, HOLD)
//   DEF_*       : default parameter values for the collector
//   beat_cnt_w  : width of a counter that must hold 0..BEATS inclusive
package result_collector_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_BEATS   = 100;
  localparam int DEF_LATENCY = 1;
  localparam int DEF_CNT_W   = 16;

  function automatic int beat_cnt_w(input int beats);
    return $clog2(beats + 1);
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// rtl/delay_pipe.sv - fixed-depth shift register with synchronous active-high reset
// Ports:
//   clk   : clock, all stages advance on posedge
//   reset : synchronous, active-high; clears every stage
//   din   : value entering stage 0
//   dout  : value leaving the last stage, DEPTH cycles after din
module delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - aligns DUT results to stimulus beats and packs them into handshaked frames
// Optional feature macro: RESULT_COLLECTOR_CHECK_EN (builds the expected-sum pipe and mismatch counters)
// Ports:
//   clk, reset        : single clock, synchronous active-high reset
//   stim_valid/a/b    : operand pair issued to the DUT this cycle
//   res_i             : DUT result bus, sampled LATENCY cycles after its stimulus
//   out_valid/ready   : frame handshake; out_data holds beat k at [k*DATA_W +: DATA_W]
//   beat_cnt          : beats captured in the current frame (BEATS while a frame is held)
//   overflow/drop_cnt : sticky drop flag and saturating drop count
//   mismatch/_cnt     : sticky flag and saturating count of wrong results (0 unless CHECK_EN)
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int LATENCY = DEF_LATENCY,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          stim_valid,
  input  logic [DATA_W-1:0]             stim_a,
  input  logic [DATA_W-1:0]             stim_b,
  input  logic [DATA_W-1:0]             res_i,
  output logic                          out_valid,
  output logic [DATA_W*BEATS-1:0]       out_data,
  input  logic                          out_ready,
  output logic [beat_cnt_w(BEATS)-1:0]  beat_cnt,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic                          mismatch,
  output logic [CNT_W-1:0]              mismatch_cnt
);

  localparam int BCW = beat_cnt_w(BEATS);
  localparam logic [BCW-1:0] LAST = BCW'(BEATS - 1);

  state_t            state, state_n;
  logic              beat_v;
  logic              capture;
  logic              clear;
  logic              drop;
  logic [DATA_W-1:0] slot [BEATS];

  delay_pipe #(.WIDTH(1), .DEPTH(LATENCY)) u_valid_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (stim_valid),
    .dout  (beat_v)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= COLLECT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    capture = 1'b0;
    clear   = 1'b0;
    drop    = 1'b0;
    case (state)
      COLLECT: begin
        if (beat_v) begin
          capture = 1'b1;
          if (beat_cnt == LAST) state_n = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          // A beat arriving with the handshake opens the next frame at slot 0;
          // with single-beat frames that alone completes the next frame.
          clear   = 1'b1;
          capture = beat_v;
          state_n = (beat_v && LAST == '0) ? HOLD : COLLECT;
        end else if (beat_v) begin
          drop = 1'b1;
        end
      end
      default: state_n = COLLECT;
    endcase
  end

  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int k = 0; k < BEATS; k++) slot[k] <= '0;
    end else begin
      if (clear) begin
        beat_cnt <= capture ? BCW'(1) : '0;
        for (int k = 0; k < BEATS; k++) slot[k] <= '0;
        if (capture) slot[0] <= res_i;
      end else if (capture) begin
        beat_cnt <= beat_cnt + BCW'(1);
        for (int k = 0; k < BEATS; k++) begin
          if (beat_cnt == BCW'(k)) slot[k] <= res_i;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

  for (genvar k = 0; k < BEATS; k++) begin : g_pack
    assign out_data[k*DATA_W +: DATA_W] = slot[k];
  end

`ifdef RESULT_COLLECTOR_CHECK_EN
  logic [DATA_W-1:0] stim_sum;
  logic [DATA_W-1:0] exp_sum;

  assign stim_sum = stim_a + stim_b;

  delay_pipe #(.WIDTH(DATA_W), .DEPTH(LATENCY)) u_sum_pipe (
    .clk   (clk),
    .reset (reset),
    .din   (stim_sum),
    .dout  (exp_sum)
  );

  // Checked on every aligned beat, including beats dropped while a frame is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch     <= 1'b0;
      mismatch_cnt <= '0;
    end else if (beat_v && res_i != exp_sum) begin
      mismatch <= 1'b1;
      if (mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_stim;
  assign unused_stim  = ^{stim_a, stim_b};
  assign mismatch     = 1'b0;
  assign mismatch_cnt = '0;
`endif

endmodule
